// File: rtl/memwb_pipe_stage.sv
// MEM/WB elastic pipeline stage: head register plus one skid register behind a
// valid/ready handshake, with flush, MemtoReg write-back mux and forwarding tap.
module memwb_pipe_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int WB_W   = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WB_W-1:0]   in_wb,
   input  logic [DATA_W-1:0] in_alu,
   input  logic [DATA_W-1:0] in_dm,
   input  logic [REG_W-1:0]  in_rd,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WB_W-1:0]   out_wb,
   output logic [DATA_W-1:0] out_alu,
   output logic [DATA_W-1:0] out_dm,
   output logic [REG_W-1:0]  out_rd,
   output logic [DATA_W-1:0] out_wdata,
   output logic              out_we,
   output logic              fwd_valid,
   output logic [REG_W-1:0]  fwd_rd,
   output logic [DATA_W-1:0] fwd_data
);

   // Packed beat layout: {wb, alu, dm, rd}
   localparam int P_W = WB_W + 2*DATA_W + REG_W;

   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_TWO   = 2'd2;

   logic [1:0]     state, state_nx;
   logic [P_W-1:0] h_q, h_nx;
   logic [P_W-1:0] s_q, s_nx;
   logic [P_W-1:0] in_pkt;
   logic           accept, pop;

   assign in_pkt = {in_wb, in_alu, in_dm, in_rd};

   // Handshake decode; in_ready depends only on registered state
   assign in_ready  = (state != ST_TWO);
   assign out_valid = (state != ST_EMPTY);
   assign accept    = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready;

   // Next-state and payload steering; flush wins over any accept
   always_comb begin
      state_nx = state;
      h_nx     = h_q;
      s_nx     = s_q;
      if (flush) begin
         state_nx = ST_EMPTY;
      end else begin
         case (state)
            ST_EMPTY: begin
               if (accept) begin
                  state_nx = ST_ONE;
                  h_nx     = in_pkt;
               end
            end
            ST_ONE: begin
               if (accept && pop) begin
                  h_nx = in_pkt;
               end else if (accept) begin
                  state_nx = ST_TWO;
                  s_nx     = in_pkt;
               end else if (pop) begin
                  state_nx = ST_EMPTY;
               end
            end
            ST_TWO: begin
               if (pop) begin
                  state_nx = ST_ONE;
                  h_nx     = s_q;
               end
            end
            default: state_nx = ST_EMPTY;
         endcase
      end
   end

   // State and payload registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_EMPTY;
         h_q   <= '0;
         s_q   <= '0;
      end else begin
         state <= state_nx;
         h_q   <= h_nx;
         s_q   <= s_nx;
      end
   end

   assign out_wb  = h_q[P_W-1 -: WB_W];
   assign out_alu = h_q[REG_W+DATA_W +: DATA_W];
   assign out_dm  = h_q[REG_W +: DATA_W];
   assign out_rd  = h_q[REG_W-1:0];

   // Write-back value and register-0-suppressed write enable
   assign out_wdata = out_wb[1] ? out_dm : out_alu;
   assign out_we    = out_valid & out_wb[0] & (out_rd != '0);

   assign fwd_valid = out_we;
   assign fwd_rd    = out_rd;
   assign fwd_data  = out_wdata;

endmodule

// File: tb/tb_memwb_pipe_stage.sv
// Self-checking bench for memwb_pipe_stage: queue-based reference model,
// per-cycle comparison, directed scenarios and randomized traffic.
module tb_memwb_pipe_stage;

   localparam int DATA_W = 32;
   localparam int REG_W  = 5;
   localparam int WB_W   = 2;

   typedef struct packed {
      logic [WB_W-1:0]   wb;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] dm;
      logic [REG_W-1:0]  rd;
   } beat_t;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              flush = 1'b0;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [WB_W-1:0]   in_wb = '0;
   logic [DATA_W-1:0] in_alu = '0;
   logic [DATA_W-1:0] in_dm = '0;
   logic [REG_W-1:0]  in_rd = '0;
   logic              out_valid;
   logic              out_ready = 1'b0;
   logic [WB_W-1:0]   out_wb;
   logic [DATA_W-1:0] out_alu;
   logic [DATA_W-1:0] out_dm;
   logic [REG_W-1:0]  out_rd;
   logic [DATA_W-1:0] out_wdata;
   logic              out_we;
   logic              fwd_valid;
   logic [REG_W-1:0]  fwd_rd;
   logic [DATA_W-1:0] fwd_data;

   int checks = 0;
   int errors = 0;

   memwb_pipe_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .WB_W(WB_W)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_wb(in_wb), .in_alu(in_alu), .in_dm(in_dm), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_wb(out_wb), .out_alu(out_alu), .out_dm(out_dm), .out_rd(out_rd),
      .out_wdata(out_wdata), .out_we(out_we),
      .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a FIFO of at most two beats; "shown" is what the head
   // outputs display (last head beat, or zero after reset).
   beat_t q[$];
   beat_t shown = '0;

   always @(posedge clk) begin
      bit room, acc, pp;
      beat_t b;
      if (rst) begin
         q.delete();
         shown = '0;
      end else begin
         b.wb = in_wb; b.alu = in_alu; b.dm = in_dm; b.rd = in_rd;
         room = (q.size() < 2);
         acc  = in_valid && room && !flush;
         pp   = (q.size() > 0) && out_ready;
         if (flush) q.delete();
         else begin
            if (pp)  void'(q.pop_front());
            if (acc) q.push_back(b);
         end
         if (q.size() > 0) shown = q[0];
      end
   end

   // Compare process: every cycle, away from the active edge
   always @(negedge clk) begin
      logic [DATA_W-1:0] wd;
      logic              v, we;
      v  = (q.size() > 0);
      wd = shown.wb[1] ? shown.dm : shown.alu;
      we = v && shown.wb[0] && (shown.rd != 0);
      chk("out_valid", 64'(out_valid), 64'(v));
      chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
      chk("out_wb",    64'(out_wb),    64'(shown.wb));
      chk("out_alu",   64'(out_alu),   64'(shown.alu));
      chk("out_dm",    64'(out_dm),    64'(shown.dm));
      chk("out_rd",    64'(out_rd),    64'(shown.rd));
      chk("out_wdata", 64'(out_wdata), 64'(wd));
      chk("out_we",    64'(out_we),    64'(we));
      chk("fwd_valid", 64'(fwd_valid), 64'(we));
      chk("fwd_rd",    64'(fwd_rd),    64'(shown.rd));
      chk("fwd_data",  64'(fwd_data),  64'(wd));
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] dm, input logic [4:0] rd);
      in_valid = 1'b1; in_wb = wb; in_alu = alu; in_dm = dm; in_rd = rd;
   endtask

   initial begin
      // Reset then stream
      rst = 1'b1;
      cyc(); chk("rst_valid0", 64'(out_valid), 64'd0);
      cyc(); chk("rst_valid1", 64'(out_valid), 64'd0);
      rst = 1'b0;
      chk("post_rst_ready", 64'(in_ready), 64'd1);
      chk("post_rst_wdata", 64'(out_wdata), 64'd0);
      out_ready = 1'b1;
      beat(2'b01, 32'h10, 32'hAA, 5'd3);
      cyc(); chk("s1_wdata", 64'(out_wdata), 64'h10); chk("s1_we", 64'(out_we), 64'd1);
      chk("s1_rd", 64'(out_rd), 64'd3);
      beat(2'b11, 32'h20, 32'hBB, 5'd4);
      cyc(); chk("s2_wdata", 64'(out_wdata), 64'hBB); chk("s2_we", 64'(out_we), 64'd1);
      in_valid = 1'b0;
      cyc(); chk("s_drain", 64'(out_valid), 64'd0);

      // Backpressure / skid
      out_ready = 1'b0;
      beat(2'b01, 32'd1, 32'd0, 5'd1); cyc(); chk("bp_a", 64'(out_alu), 64'd1);
      beat(2'b01, 32'd2, 32'd0, 5'd2); cyc(); chk("bp_full", 64'(in_ready), 64'd0);
      beat(2'b01, 32'd3, 32'd0, 5'd3); cyc(); chk("bp_hold_a", 64'(out_alu), 64'd1);
      chk("bp_c_blocked", 64'(in_ready), 64'd0);
      out_ready = 1'b1;
      cyc(); chk("bp_b", 64'(out_alu), 64'd2); chk("bp_ready", 64'(in_ready), 64'd1);
      cyc(); chk("bp_c", 64'(out_alu), 64'd3);
      in_valid = 1'b0;
      cyc(); chk("bp_drain", 64'(out_valid), 64'd0);

      // Flush in TWO with an incoming beat
      out_ready = 1'b0;
      beat(2'b01, 32'hA1, 32'd0, 5'd1); cyc();
      beat(2'b01, 32'hB2, 32'd0, 5'd2); cyc(); chk("fl_two", 64'(in_ready), 64'd0);
      beat(2'b01, 32'hC3, 32'd0, 5'd3); flush = 1'b1; cyc();
      chk("fl_valid", 64'(out_valid), 64'd0); chk("fl_ready", 64'(in_ready), 64'd1);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cyc(); chk("fl_no_c", 64'(out_valid), 64'd0);

      // Accept and pop together in ONE
      beat(2'b01, 32'hA5, 32'd0, 5'd5); cyc();
      beat(2'b10, 32'hD4, 32'hDD, 5'd6); cyc();
      chk("ap_alu", 64'(out_alu), 64'hD4); chk("ap_wdata", 64'(out_wdata), 64'hDD);
      chk("ap_ready", 64'(in_ready), 64'd1);
      in_valid = 1'b0; cyc();

      // Register 0 and non-writing beats
      beat(2'b01, 32'h55, 32'd0, 5'd0); cyc();
      chk("r0_valid", 64'(out_valid), 64'd1); chk("r0_we", 64'(out_we), 64'd0);
      chk("r0_fwd", 64'(fwd_valid), 64'd0); chk("r0_rd", 64'(fwd_rd), 64'd0);
      beat(2'b00, 32'h66, 32'd0, 5'd7); cyc();
      chk("nw_valid", 64'(out_valid), 64'd1); chk("nw_fwd", 64'(fwd_valid), 64'd0);
      chk("nw_rd", 64'(fwd_rd), 64'd7);
      in_valid = 1'b0; cyc();

      // Reset in TWO with a beat offered
      out_ready = 1'b0;
      beat(2'b01, 32'h71, 32'd0, 5'd1); cyc();
      beat(2'b01, 32'h72, 32'd0, 5'd2); cyc();
      beat(2'b01, 32'h73, 32'd0, 5'd3); rst = 1'b1; cyc();
      chk("mr_valid", 64'(out_valid), 64'd0); chk("mr_alu", 64'(out_alu), 64'd0);
      chk("mr_ready", 64'(in_ready), 64'd1);
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      cyc(); chk("mr_no_beat", 64'(out_valid), 64'd0);

      // Randomized traffic against the model
      for (int i = 0; i < 3000; i++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         flush     = ($urandom_range(0, 31) == 0);
         rst       = ($urandom_range(0, 299) == 0);
         in_wb     = WB_W'($urandom);
         in_alu    = $urandom;
         in_dm     = $urandom;
         in_rd     = REG_W'($urandom_range(0, 7));
         cyc();
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
      cyc(); cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
